im_loader: RTL

- Writer side of the instruction-memory read port that the single-cycle CPU fetches from.
- Receives a framed byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU in reset until the program has been loaded.

---
 rtl/im_loader_pkg.sv | 23 ++
 rtl/im_loader_byte_packer.sv | 55 +++++
 rtl/im_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_loader_pkg
// Brief    : Shared types and constants for the instruction-memory loader.
// Revision : 1.0
// ============================================================================
package im_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage
`default_nettype wire

// File: rtl/im_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : 8-to-32 big-endian packer; the completed word and full flag are
//            registered together on the 4th byte.
// Revision : 1.0
// ============================================================================
module byte_packer
  import im_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [1:0]        count_o,
  output logic              full_o
);

  logic [WORD_W-9:0] sr_q;
  logic [1:0]        cnt_q;
  logic              full_q;
  logic [WORD_W-1:0] word_q;

  // word_q changes only when a word completes, so it holds between writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
      word_q <= '0;
    end else if (clear_i) begin
      sr_q   <= '0;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      full_q <= 1'b0;
      if (shift_i) begin
        sr_q  <= {sr_q[WORD_W-17:0], byte_i};
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
          word_q <= {sr_q, byte_i};
          full_q <= 1'b1;
        end
      end
    end
  end

  assign word_o  = word_q;
  assign count_o = cnt_q;
  assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Brief    : Loads a framed byte stream into instruction memory as 32-bit
//            big-endian words and holds the CPU in reset until done.
// Revision : 1.0
// ============================================================================
module im_loader
  import im_loader_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [16:0]       C_DEPTH = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);

  state_e            state_q;
  logic [15:0]       n_q;
  logic              hdr_cnt_q;
  logic [15:0]       wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              byte_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              cpu_hold_q;

  logic              w_accept;
  logic              w_start_ok;
  logic [15:0]       w_hdr_n;
  logic [15:0]       w_wcnt_inc;
  logic              w_too_long;
  logic [1:0]        w_pk_count;
  logic              w_pk_full;
  logic [WORD_W-1:0] w_pk_word;

  assign w_accept   = byte_valid & byte_ready_q;
  assign w_start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign w_hdr_n    = {n_q[15:8], byte_data};
  assign w_wcnt_inc = wcnt_q + 16'd1;
  assign w_too_long = {1'b0, w_hdr_n} > C_DEPTH;

  // The packer's registered full flag is the write strobe: high only in WRITE.
  byte_packer u_packer (
    .clock   (clock),
    .reset   (reset),
    .clear_i (w_start_ok),
    .shift_i (w_accept && (state_q == S_LOAD)),
    .byte_i  (byte_data),
    .word_o  (w_pk_word),
    .count_o (w_pk_count),
    .full_o  (w_pk_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= 16'd0;
      hdr_cnt_q    <= 1'b0;
      wcnt_q       <= 16'd0;
      addr_q       <= C_BASE;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_HDR;
            hdr_cnt_q    <= 1'b0;
            wcnt_q       <= 16'd0;
            addr_q       <= C_BASE;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (hdr_cnt_q != 1'(HDR_BYTES - 1)) begin
              n_q[15:8] <= byte_data;
              hdr_cnt_q <= 1'b1;
            end else begin
              n_q       <= w_hdr_n;
              hdr_cnt_q <= 1'b0;
              if (w_hdr_n == 16'd0) begin
                state_q      <= S_DONE;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                cpu_hold_q   <= 1'b0;
              end else if (w_too_long) begin
                state_q      <= S_ERR;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                error_q      <= 1'b1;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (w_accept && (w_pk_count == 2'(BYTES_PER_WORD - 1))) begin
            state_q      <= S_WRITE;
            byte_ready_q <= 1'b0;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          wcnt_q <= w_wcnt_inc;
          if (w_wcnt_inc == n_q) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q      <= S_LOAD;
            byte_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = w_pk_full;
  assign im_addr    = addr_q;
  assign im_wdata   = w_pk_word;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire
